vga_frame_scanner: RTL and testbench

VGA_FRAME_SCANNER -- requirements
Module: vga_frame_scanner

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing_gen.sv | 60 ++++++
 rtl/vga_frame_scanner.sv | 129 ++++++++++++
 tb/tb_vga_frame_scanner.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA 640x480@60 timing, framebuffer geometry and sync bundle type
package vga_pkg;
   localparam int H_VISIBLE   = 640;
   localparam int H_FRONT     = 16;
   localparam int H_SYNC      = 96;
   localparam int H_BACK      = 48;
   localparam int V_VISIBLE   = 480;
   localparam int V_FRONT     = 10;
   localparam int V_SYNC      = 2;
   localparam int V_BACK      = 33;
   localparam int FB_WIDTH    = 160;
   localparam int FB_HEIGHT   = 120;
   localparam int FB_DEPTH    = FB_WIDTH * FB_HEIGHT;
   localparam int FB_AW       = $clog2(FB_DEPTH);
   localparam int COLOUR_BITS = 3;
   localparam int DAC_BITS    = 10;
   localparam int CNT_W       = 10;

   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic visible;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, visible: 1'b0};
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate h/v counters with raw (unregistered) syncs and visible flag
//   clk, resetn : system clock, synchronous active-low reset
//   pe          : pixel enable, counters advance when high
//   hcount      : 0 .. H_TOTAL-1, vcount : 0 .. V_TOTAL-1
//   sync        : active-low hs/vs and visible, decoded from the current counts
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VIS = H_VISIBLE,
   parameter int H_FP  = H_FRONT,
   parameter int H_SW  = H_SYNC,
   parameter int H_BP  = H_BACK,
   parameter int V_VIS = V_VISIBLE,
   parameter int V_FP  = V_FRONT,
   parameter int V_SW  = V_SYNC,
   parameter int V_BP  = V_BACK
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             pe,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output sync_t            sync
);
   localparam int H_TOTAL  = H_VIS + H_FP + H_SW + H_BP;
   localparam int V_TOTAL  = V_VIS + V_FP + V_SW + V_BP;
   localparam int HS_START = H_VIS + H_FP;
   localparam int VS_START = V_VIS + V_FP;

   logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
   logic             h_wrap, v_wrap;

   always_comb begin
      h_wrap   = hcount_q == CNT_W'(H_TOTAL - 1);
      v_wrap   = vcount_q == CNT_W'(V_TOTAL - 1);
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (pe) begin
         hcount_d = h_wrap ? '0 : hcount_q + CNT_W'(1);
         if (h_wrap)
            vcount_d = v_wrap ? '0 : vcount_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         hcount_q <= '0;
         vcount_q <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
      end
   end

   assign hcount       = hcount_q;
   assign vcount       = vcount_q;
   assign sync.hs_n    = !(hcount_q >= CNT_W'(HS_START) && hcount_q < CNT_W'(HS_START + H_SW));
   assign sync.vs_n    = !(vcount_q >= CNT_W'(VS_START) && vcount_q < CNT_W'(VS_START + V_SW));
   assign sync.visible = hcount_q < CNT_W'(H_VIS) && vcount_q < CNT_W'(V_VIS);
endmodule

// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: 160x120 framebuffer scanned out as 640x480 VGA with 4x4 pixel replication
//   clk, resetn      : 50 MHz system clock, synchronous active-low reset
//   colour, x, y     : {R,G,B} value written at (x,y) when plot is high
//   VGA_R/G/B        : 10-bit DAC colour, zero outside the visible area
//   VGA_HS, VGA_VS   : active-low syncs; VGA_BLANK_N high while visible
//   VGA_SYNC_N       : tied high; VGA_CLK : 25 MHz pixel clock, rising mid-pixel
module vga_frame_scanner
   import vga_pkg::*;
#(
   parameter string BACKGROUND_IMAGE        = "defense_map_with_turn.mif",
   parameter int    BITS_PER_COLOUR_CHANNEL = COLOUR_BITS,
   parameter int    H_VIS                   = H_VISIBLE,
   parameter int    H_FP                    = H_FRONT,
   parameter int    H_SW                    = H_SYNC,
   parameter int    H_BP                    = H_BACK,
   parameter int    V_VIS                   = V_VISIBLE,
   parameter int    V_FP                    = V_FRONT,
   parameter int    V_SW                    = V_SYNC,
   parameter int    V_BP                    = V_BACK
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic [3*BITS_PER_COLOUR_CHANNEL-1:0] colour,
   input  logic [7:0]                           x,
   input  logic [6:0]                           y,
   input  logic                                 plot,
   output logic [DAC_BITS-1:0]                  VGA_R,
   output logic [DAC_BITS-1:0]                  VGA_G,
   output logic [DAC_BITS-1:0]                  VGA_B,
   output logic                                 VGA_HS,
   output logic                                 VGA_VS,
   output logic                                 VGA_BLANK_N,
   output logic                                 VGA_SYNC_N,
   output logic                                 VGA_CLK
);
   localparam int CW = BITS_PER_COLOUR_CHANNEL;
   localparam int PW = 3 * CW;

   // Repeat the channel MSB-first until the DAC word is full, so full scale maps to all ones.
   function automatic logic [DAC_BITS-1:0] expand(input logic [CW-1:0] c);
      logic [DAC_BITS-1:0] e;
      for (int i = 0; i < DAC_BITS; i++) e[DAC_BITS-1-i] = c[CW-1-(i % CW)];
      return e;
   endfunction

   (* ram_init_file = BACKGROUND_IMAGE *) logic [PW-1:0] fb_mem [FB_DEPTH];

   logic [CNT_W-1:0]    hcount, vcount;
   sync_t               sync;
   logic                we;
   logic [FB_AW-1:0]    waddr, raddr;
   logic [PW-1:0]       rd_q;
   logic                pe_q, pe_d, vga_clk_q, vga_clk_d;
   sync_t               sync1_q, sync1_d;
   logic                hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
   logic [DAC_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

   vga_timing_gen #(
      .H_VIS (H_VIS), .H_FP (H_FP), .H_SW (H_SW), .H_BP (H_BP),
      .V_VIS (V_VIS), .V_FP (V_FP), .V_SW (V_SW), .V_BP (V_BP)
   ) u_timing (
      .clk    (clk),
      .resetn (resetn),
      .pe     (pe_q),
      .hcount (hcount),
      .vcount (vcount),
      .sync   (sync)
   );

   always_comb begin
      we    = resetn && plot && x < 8'(FB_WIDTH) && y < 7'(FB_HEIGHT);
      waddr = FB_AW'(int'(y) * FB_WIDTH + int'(x));
      raddr = FB_AW'(int'(vcount >> 2) * FB_WIDTH + int'(hcount >> 2));
   end

   // Both ports in one process with non-blocking updates: a read of the address
   // being written in the same cycle returns the old word.
   always_ff @(posedge clk) begin
      if (we) fb_mem[waddr] <= colour;
      if (pe_q) rd_q <= fb_mem[raddr];
   end

   // Stage 1 (sync1_q, rd_q) samples the counters; stage 2 is the output register.
   // vga_clk_q ends up equal to pe_q, so VGA_CLK rises half a pixel after the data changes.
   always_comb begin
      pe_d      = ~pe_q;
      vga_clk_d = ~pe_q;
      sync1_d   = pe_q ? sync : sync1_q;
      hs_d      = pe_q ? sync1_q.hs_n : hs_q;
      vs_d      = pe_q ? sync1_q.vs_n : vs_q;
      blank_n_d = pe_q ? sync1_q.visible : blank_n_q;
      r_d       = pe_q ? (sync1_q.visible ? expand(rd_q[PW-1 -: CW]) : '0) : r_q;
      g_d       = pe_q ? (sync1_q.visible ? expand(rd_q[2*CW-1 -: CW]) : '0) : g_q;
      b_d       = pe_q ? (sync1_q.visible ? expand(rd_q[CW-1:0]) : '0) : b_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pe_q      <= 1'b0;
         vga_clk_q <= 1'b0;
         sync1_q   <= SYNC_IDLE;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
      end else begin
         pe_q      <= pe_d;
         vga_clk_q <= vga_clk_d;
         sync1_q   <= sync1_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         blank_n_q <= blank_n_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
      end
   end

   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_SYNC_N  = 1'b1;
   assign VGA_CLK     = vga_clk_q;
endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: directed checks of scan-out, syncs, write filtering and reset on a shrunken raster
module tb_vga_frame_scanner;
   localparam int HV = 32, HF = 4, HSW = 8, HB = 4;
   localparam int VV = 32, VF = 2, VSW = 2, VB = 2;
   localparam int HT = HV + HF + HSW + HB;
   localparam int VT = VV + VF + VSW + VB;
   localparam int FR = HT * VT;

   typedef struct {
      int         h, v;
      logic [9:0] r, g, b;
      logic       hs, vs, bn;
   } vec_t;

   logic       clk = 1'b0, resetn = 1'b0, plot = 1'b0;
   logic [8:0] colour = '0;
   logic [7:0] x = '0;
   logic [6:0] y = '0;
   logic [9:0] vga_r, vga_g, vga_b;
   logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;
   int         edges = 0;
   int         n_checks = 0, n_fail = 0;

   localparam logic [34:0] RESET_OUT = {30'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

   vga_frame_scanner #(
      .H_VIS (HV), .H_FP (HF), .H_SW (HSW), .H_BP (HB),
      .V_VIS (VV), .V_FP (VF), .V_SW (VSW), .V_BP (VB)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .colour      (colour),
      .x           (x),
      .y           (y),
      .plot        (plot),
      .VGA_R       (vga_r),
      .VGA_G       (vga_g),
      .VGA_B       (vga_b),
      .VGA_HS      (vga_hs),
      .VGA_VS      (vga_vs),
      .VGA_BLANK_N (vga_blank_n),
      .VGA_SYNC_N  (vga_sync_n),
      .VGA_CLK     (vga_clk)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edges <= resetn ? edges + 1 : 0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, edges=%0d", edges);
      $fatal(1);
   end

   function automatic logic [34:0] outv();
      return {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_clk, vga_sync_n};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Returns at the negedge after the posedge that brings the edge count to target.
   task automatic wait_edges(input int target);
      for (int g = 0; edges < target && g < 200000; g++) @(negedge clk);
      if (edges != target) check("sync_point", 64'(edges), 64'(target));
   endtask

   function automatic int pix(input int f, input int h, input int v);
      return f * FR + v * HT + h;
   endfunction

   // Pixel n is read on edge 2+2n and presented on edge 4+2n after reset release.
   task automatic at_pixel(input int n);
      wait_edges(4 + 2 * n);
   endtask

   task automatic wr(input int xx, input int yy, input logic [8:0] c);
      x      = 8'(xx);
      y      = 7'(yy);
      colour = c;
      plot   = 1'b1;
      @(negedge clk);
      plot   = 1'b0;
   endtask

   initial begin
      vec_t tbl [21];
      int   first, last, cnt, n8;
      tbl[0]  = '{0,  0,  10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b1};
      tbl[1]  = '{4,  0,  10'h092, 10'h000, 10'h092, 1'b1, 1'b1, 1'b1};
      tbl[2]  = '{32, 0,  10'h000, 10'h000, 10'h000, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{35, 0,  10'h000, 10'h000, 10'h000, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{36, 0,  10'h000, 10'h000, 10'h000, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{43, 0,  10'h000, 10'h000, 10'h000, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{44, 0,  10'h000, 10'h000, 10'h000, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{3,  3,  10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b1};
      tbl[8]  = '{0,  4,  10'h000, 10'h092, 10'h092, 1'b1, 1'b1, 1'b1};
      tbl[9]  = '{47, 5,  10'h000, 10'h000, 10'h000, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{20, 10, 10'h2DB, 10'h124, 10'h3FF, 1'b1, 1'b1, 1'b1};
      tbl[11] = '{16, 16, 10'h249, 10'h249, 10'h000, 1'b1, 1'b1, 1'b1};
      tbl[12] = '{0,  24, 10'h000, 10'h36D, 10'h36D, 1'b1, 1'b1, 1'b1};
      tbl[13] = '{28, 28, 10'h249, 10'h000, 10'h000, 1'b1, 1'b1, 1'b1};
      tbl[14] = '{27, 31, 10'h36D, 10'h3FF, 10'h2DB, 1'b1, 1'b1, 1'b1};
      tbl[15] = '{31, 31, 10'h249, 10'h000, 10'h000, 1'b1, 1'b1, 1'b1};
      tbl[16] = '{0,  32, 10'h000, 10'h000, 10'h000, 1'b1, 1'b1, 1'b0};
      tbl[17] = '{0,  33, 10'h000, 10'h000, 10'h000, 1'b1, 1'b1, 1'b0};
      tbl[18] = '{0,  34, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0};
      tbl[19] = '{10, 35, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0};
      tbl[20] = '{0,  36, 10'h000, 10'h000, 10'h000, 1'b1, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      check("reset_outputs", 64'(outv()), 64'(RESET_OUT));
      resetn = 1'b1;

      for (int yy = 0; yy < 8; yy++)
         for (int xx = 0; xx < 8; xx++)
            wr(xx, yy, {3'(xx), 3'(yy), 3'(xx + yy)});
      wr(0, 0, 9'h1FF);
      wr(7, 7, 9'h100);
      wr(160, 5, 9'h1FF);
      for (int xx = 8; xx < 12; xx++) wr(xx, 0, 9'h1FF);
      wr(0, 8, 9'h1FF);

      for (int i = 0; i < 21; i++) begin
         at_pixel(pix(1, tbl[i].h, tbl[i].v));
         check($sformatf("vec%0d_h%0d_v%0d", i, tbl[i].h, tbl[i].v), 64'(outv()),
               64'({tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].hs, tbl[i].vs, tbl[i].bn, 1'b0, 1'b1}));
      end

      first = -1; last = -1; cnt = 0;
      for (int i = 0; i < 2 * HT; i++) begin
         at_pixel(pix(2, 0, 3) + i);
         if (!vga_hs) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      check("hs_first_low", 64'(first), 64'(36));
      check("hs_low_pixels_two_lines", 64'(cnt), 64'(16));
      check("hs_last_low", 64'(last), 64'(91));
      @(negedge clk);
      check("vga_clk_mid_pixel", 64'(vga_clk), 64'(1));

      first = -1; cnt = 0;
      for (int v = 0; v < VT; v++) begin
         at_pixel(pix(3, 0, v));
         if (!vga_vs) begin
            cnt++;
            if (first < 0) first = v;
         end
      end
      check("vs_first_low_line", 64'(first), 64'(34));
      check("vs_low_lines", 64'(cnt), 64'(2));

      n8 = pix(4, 8, 0);
      wait_edges(1 + 2 * n8);
      wr(2, 0, 9'h1C0);
      at_pixel(n8);
      check("raw_same_cycle_old", 64'(outv()), 64'({10'h124, 10'h000, 10'h124, 5'b11101}));
      at_pixel(n8 + 1);
      check("raw_next_pixel_new", 64'(outv()), 64'({10'h3FF, 10'h000, 10'h000, 5'b11101}));
      at_pixel(pix(5, 8, 0));
      check("raw_next_frame_new", 64'(outv()), 64'({10'h3FF, 10'h000, 10'h000, 5'b11101}));

      wait_edges(4 + 2 * pix(6, 0, 10));
      resetn = 1'b0;
      x = 8'd1; y = 7'd1; colour = 9'h000; plot = 1'b1;
      @(negedge clk);
      check("midreset_outputs", 64'(outv()), 64'(RESET_OUT));
      resetn = 1'b1;
      plot = 1'b0;
      at_pixel(pix(0, 0, 0));
      check("restart_pixel_0_0", 64'(outv()), 64'({10'h3FF, 10'h3FF, 10'h3FF, 5'b11101}));
      at_pixel(pix(0, 47, 33));
      check("restart_vs_before", 64'(vga_vs), 64'(1));
      at_pixel(pix(0, 0, 34));
      check("restart_vs_start", 64'(vga_vs), 64'(0));
      at_pixel(pix(1, 4, 4));
      check("reset_write_ignored", 64'(outv()), 64'({10'h092, 10'h092, 10'h124, 5'b11101}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
